// File: rtl/axi4l_reg_file_if.sv
// Bus bundle between the AXI4-Lite channel logic and the register file:
// the decoded write strobe, the read request and the read response.
interface axi4l_reg_file_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] i_waddr;
   logic [DATA_WIDTH-1:0] i_wdata;
   logic                  i_wvalid;
   logic [ADDR_WIDTH-1:0] i_raddr;
   logic                  i_rvalid;
   logic [DATA_WIDTH-1:0] o_rdata;
   logic                  o_rvalid;
   logic                  o_rerr;

   modport master (
      output i_waddr, i_wdata, i_wvalid, i_raddr, i_rvalid,
      input  o_rdata, o_rvalid, o_rerr
   );

   modport slave (
      input  i_waddr, i_wdata, i_wvalid, i_raddr, i_rvalid,
      output o_rdata, o_rvalid, o_rerr
   );
endinterface

// File: rtl/axi4l_reg_file.sv
// Register file behind the AXI4-Lite write channel: control, scratch,
// counter/compare, W1C interrupt registers and a one-cycle read port.
module axi4l_reg_file #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic               i_axi_clock,
   input  logic               i_axi_reset,
   axi4l_reg_file_if.slave    bus,
   output logic               o_ctrl_enable,
   output logic               o_irq
);

   localparam logic [2:0] IDX_CTRL    = 3'd0;
   localparam logic [2:0] IDX_STATUS  = 3'd1;
   localparam logic [2:0] IDX_SCRATCH = 3'd2;
   localparam logic [2:0] IDX_IRQST   = 3'd3;
   localparam logic [2:0] IDX_IRQEN   = 3'd4;
   localparam logic [2:0] IDX_COUNT   = 3'd5;
   localparam logic [2:0] IDX_COMPARE = 3'd6;
   localparam logic [2:0] IDX_WRCOUNT = 3'd7;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(28);
   localparam logic [DATA_WIDTH-1:0] ALL_ONES  = '1;

   logic                  ctrl_en;
   logic [DATA_WIDTH-1:0] scratch;
   logic [1:0]            irq_st;
   logic [1:0]            irq_en;
   logic [DATA_WIDTH-1:0] count;
   logic [DATA_WIDTH-1:0] compare;
   logic [DATA_WIDTH-1:0] wr_count;

   logic [DATA_WIDTH-1:0] rdata_p1;
   logic                  vld_p1;
   logic                  rerr_p1;

   logic                  wr_map;
   logic [2:0]            wr_idx;
   logic                  rd_map;
   logic [2:0]            rd_idx;
   logic                  wr_ctrl;
   logic                  wr_bad;
   logic                  match;
   logic [1:0]            irq_clr;
   logic [1:0]            irq_st_nxt;
   logic [DATA_WIDTH-1:0] rd_mux;

   // Mapped means word aligned and no higher than the last register.
   function automatic logic addr_mapped(input logic [ADDR_WIDTH-1:0] a);
      return (a[1:0] == 2'b00) && (a <= LAST_ADDR);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] sat_inc(input logic [DATA_WIDTH-1:0] v);
      return (v == ALL_ONES) ? v : v + 1'b1;
   endfunction

   always_comb begin
      wr_map  = addr_mapped(bus.i_waddr);
      wr_idx  = bus.i_waddr[4:2];
      rd_map  = addr_mapped(bus.i_raddr);
      rd_idx  = bus.i_raddr[4:2];
      wr_ctrl = bus.i_wvalid && wr_map && (wr_idx == IDX_CTRL);
      wr_bad  = bus.i_wvalid && (!wr_map || (wr_idx == IDX_STATUS) ||
                                 (wr_idx == IDX_COUNT) || (wr_idx == IDX_WRCOUNT));
      match   = ctrl_en && (count == compare);
      irq_clr = (bus.i_wvalid && wr_map && (wr_idx == IDX_IRQST)) ? bus.i_wdata[1:0] : 2'b00;
      // Hardware set is applied after the W1C clear so it wins a same-cycle race.
      irq_st_nxt = (irq_st & ~irq_clr) | {wr_bad, match};
   end

   always_comb begin
      rd_mux = '0;
      case (rd_idx)
         IDX_CTRL:    rd_mux = {{(DATA_WIDTH-1){1'b0}}, ctrl_en};
         IDX_STATUS:  rd_mux = {{(DATA_WIDTH-2){1'b0}}, o_irq, ctrl_en};
         IDX_SCRATCH: rd_mux = scratch;
         IDX_IRQST:   rd_mux = {{(DATA_WIDTH-2){1'b0}}, irq_st};
         IDX_IRQEN:   rd_mux = {{(DATA_WIDTH-2){1'b0}}, irq_en};
         IDX_COUNT:   rd_mux = count;
         IDX_COMPARE: rd_mux = compare;
         IDX_WRCOUNT: rd_mux = wr_count;
         default:     rd_mux = '0;
      endcase
   end

   always_ff @(posedge i_axi_clock) begin
      if (i_axi_reset) begin
         ctrl_en  <= 1'b0;
         scratch  <= '0;
         irq_st   <= '0;
         irq_en   <= '0;
         count    <= '0;
         compare  <= '0;
         wr_count <= '0;
         o_irq    <= 1'b0;
      end else begin
         if (wr_ctrl) ctrl_en <= bus.i_wdata[0];
         if (bus.i_wvalid && wr_map && (wr_idx == IDX_SCRATCH)) scratch <= bus.i_wdata;
         if (bus.i_wvalid && wr_map && (wr_idx == IDX_IRQEN))   irq_en  <= bus.i_wdata[1:0];
         if (bus.i_wvalid && wr_map && (wr_idx == IDX_COMPARE)) compare <= bus.i_wdata;
         if (bus.i_wvalid) wr_count <= sat_inc(wr_count);

         if (wr_ctrl && bus.i_wdata[1])
            count <= '0;
         else if (ctrl_en)
            count <= count + 1'b1;

         irq_st <= irq_st_nxt;
         o_irq  <= |(irq_st & irq_en);
      end
   end

   // Read response stage: registers sampled in the request cycle.
   always_ff @(posedge i_axi_clock) begin
      if (i_axi_reset) begin
         rdata_p1 <= '0;
         vld_p1   <= 1'b0;
         rerr_p1  <= 1'b0;
      end else begin
         vld_p1 <= bus.i_rvalid;
         if (bus.i_rvalid) begin
            rdata_p1 <= rd_map ? rd_mux : '0;
            rerr_p1  <= !rd_map;
         end
      end
   end

   assign bus.o_rdata   = rdata_p1;
   assign bus.o_rvalid  = vld_p1;
   assign bus.o_rerr    = rerr_p1;
   assign o_ctrl_enable = ctrl_en;

endmodule
